glitch_ack_framer: RTL and testbench

- Downstream of the duration counter: consumes the glitch-complete pulse and reports each completed glitch to the host as a framed UART message.
- Each report carries a sequence number, the low bytes of the glitch parameters and a checksum.
- Drives the byte-level uart_tx transmitter through its en/busy handshake.
- Owns the host TX line mux: the framer's serial output while a frame is in flight, target_rx passthrough otherwise.

---
 rtl/glitch_ack_framer.sv | 166 ++++++++++++++++
 tb/tb_glitch_ack_framer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_ack_framer.sv
// Reports each completed glitch to the host as a 5-byte UART frame (SOF, seq, ofs_lo, dur_lo, CHK).
// Also owns the host TX line: framer output while a frame is in flight, otherwise target_rx passthrough.
module glitch_ack_framer #(
  parameter logic [7:0]  SOF          = 8'hA5,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse_done,
  input  logic [31:0] glitch_ofs,
  input  logic [31:0] glitch_dur,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_busy,
  input  logic        ack_line,
  input  logic        target_rx,
  output logic        uart_line,
  output logic        frame_active,
  output logic [7:0]  seq,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO, NEXT} state_e;

  state_e        state_q, state_d;
  logic          pulse_q, pulse_d;
  logic          pending_q, pending_d;
  logic [7:0]    slot_ofs_q, slot_ofs_d;
  logic [7:0]    slot_dur_q, slot_dur_d;
  logic [7:0]    frm_ofs_q, frm_ofs_d;
  logic [7:0]    frm_dur_q, frm_dur_d;
  logic [2:0]    idx_q, idx_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          frame_active_q, frame_active_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    drop_q, drop_d;
  logic [7:0]    byte_sel;
  logic          event_w;
  logic          consume_w;
  logic          unused_hi_bits;

  assign unused_hi_bits = ^{glitch_ofs[31:8], glitch_dur[31:8]};

  always_comb begin
    byte_sel = SOF;
    case (idx_q)
      3'd0:    byte_sel = SOF;
      3'd1:    byte_sel = seq_q;
      3'd2:    byte_sel = frm_ofs_q;
      3'd3:    byte_sel = frm_dur_q;
      default: byte_sel = seq_q ^ frm_ofs_q ^ frm_dur_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pulse_d        = pulse_done;
    pending_d      = pending_q;
    slot_ofs_d     = slot_ofs_q;
    slot_dur_d     = slot_dur_q;
    frm_ofs_d      = frm_ofs_q;
    frm_dur_d      = frm_dur_q;
    idx_d          = idx_q;
    to_cnt_d       = to_cnt_q;
    tx_data_d      = tx_data_q;
    tx_en_d        = 1'b0;
    frame_active_d = frame_active_q;
    seq_d          = seq_q;
    drop_d         = drop_q;

    event_w   = pulse_done & ~pulse_q;
    consume_w = (state_q == LOAD);

    // A consume in the same cycle frees the slot first, so the new event lands instead of dropping.
    if (consume_w) pending_d = 1'b0;
    if (event_w) begin
      if (pending_q && !consume_w) begin
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end else begin
        pending_d  = 1'b1;
        slot_ofs_d = glitch_ofs[7:0];
        slot_dur_d = glitch_dur[7:0];
      end
    end

    case (state_q)
      IDLE: if (pending_q) state_d = LOAD;
      LOAD: begin
        frm_ofs_d      = slot_ofs_q;
        frm_dur_d      = slot_dur_q;
        idx_d          = 3'd0;
        frame_active_d = 1'b1;
        state_d        = STROBE;
      end
      STROBE: if (!tx_busy) begin
        tx_data_d = byte_sel;
        tx_en_d   = 1'b1;
        to_cnt_d  = '0;
        state_d   = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy)                              state_d  = WAIT_LO;
        else if (to_cnt_q == TW'(BUSY_TIMEOUT - 1)) state_d  = NEXT;
        else                                      to_cnt_d = to_cnt_q + TW'(1);
      end
      WAIT_LO: if (!tx_busy) state_d = NEXT;
      NEXT: begin
        if (idx_q == 3'd4) begin
          seq_d          = seq_q + 8'd1;
          frame_active_d = 1'b0;
          state_d        = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = STROBE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pulse_q        <= 1'b0;
      pending_q      <= 1'b0;
      slot_ofs_q     <= '0;
      slot_dur_q     <= '0;
      frm_ofs_q      <= '0;
      frm_dur_q      <= '0;
      idx_q          <= '0;
      to_cnt_q       <= '0;
      tx_data_q      <= '0;
      tx_en_q        <= 1'b0;
      frame_active_q <= 1'b0;
      seq_q          <= '0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      pulse_q        <= pulse_d;
      pending_q      <= pending_d;
      slot_ofs_q     <= slot_ofs_d;
      slot_dur_q     <= slot_dur_d;
      frm_ofs_q      <= frm_ofs_d;
      frm_dur_q      <= frm_dur_d;
      idx_q          <= idx_d;
      to_cnt_q       <= to_cnt_d;
      tx_data_q      <= tx_data_d;
      tx_en_q        <= tx_en_d;
      frame_active_q <= frame_active_d;
      seq_q          <= seq_d;
      drop_q         <= drop_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_en        = tx_en_q;
  assign frame_active = frame_active_q;
  assign seq          = seq_q;
  assign drop_cnt     = drop_q;
  assign uart_line    = frame_active_q ? ack_line : target_rx;

endmodule

// File: tb/tb_glitch_ack_framer.sv
// Directed bench for glitch_ack_framer: frame bytes are queued when events are driven and
// checked as the framer strobes them out to a small UART transmitter model.
module tb_glitch_ack_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pulse_done;
  logic [31:0] glitch_ofs, glitch_dur;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic        ack_line;
  logic        target_rx;
  logic        uart_line;
  logic        frame_active;
  logic [7:0]  seq, drop_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  tb_seq;
  int          bytes_seen = 0;
  int          busy_cnt = 0;
  int          busy_len = 6;
  bit          no_busy = 1'b0;

  glitch_ack_framer #(.SOF(8'hA5), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .pulse_done(pulse_done),
    .glitch_ofs(glitch_ofs), .glitch_dur(glitch_dur),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .ack_line(ack_line), .target_rx(target_rx), .uart_line(uart_line),
    .frame_active(frame_active), .seq(seq), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] s, input logic [7:0] o, input logic [7:0] d);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s);
    exp_q.push_back(o);
    exp_q.push_back(d);
    exp_q.push_back(s ^ o ^ d);
  endtask

  // Rising edge on pulse_done; parameters scrambled after the sampling edge.
  task automatic fire(input logic [7:0] o, input logic [7:0] d);
    glitch_ofs = {24'hC0FFEE, o};
    glitch_dur = {24'h5EED00, d};
    pulse_done = 1'b1;
    @(posedge clk); #1;
    glitch_ofs = '1;
    glitch_dur = '1;
    @(posedge clk); #1;
    pulse_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      target_rx = ~target_rx;
      #1;
      if (frame_active) chk("mux_frame", uart_line, ack_line);
      else              chk("mux_idle", uart_line, target_rx);
      if (exp_q.size() == 0 && !frame_active) break;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_active"}, frame_active, 0);
  endtask

  // Transmitter model and scoreboard pop.
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      bytes_seen++;
      chk("byte_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) chk("tx_byte", tx_data, exp_q.pop_front());
      if (!no_busy) busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy  = (busy_cnt > 0);
    ack_line = (busy_cnt > 0) ? busy_cnt[0] : 1'b1;
  end

  initial begin
    int cnt;
    int base;
    tx_busy    = 1'b0;
    ack_line   = 1'b1;
    rst        = 1'b1;
    pulse_done = 1'b0;
    glitch_ofs = '0;
    glitch_dur = '0;
    target_rx  = 1'b1;
    tb_seq     = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_seq", seq, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    target_rx = 1'b0; #1;
    chk("rst_mux0", uart_line, 0);
    target_rx = 1'b1; #1;
    chk("rst_mux1", uart_line, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single event with known bytes and latency
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'hAB);
    exp_q.push_back(8'h34); exp_q.push_back(8'h9F);
    glitch_ofs = 32'h0000_12AB;
    glitch_dur = 32'h0000_0034;
    pulse_done = 1'b1;
    @(posedge clk); #1;
    chk("lat_fa_e0", frame_active, 0);
    @(posedge clk); #1;
    pulse_done = 1'b0;
    chk("lat_fa_e1", frame_active, 0);
    @(posedge clk); #1;
    chk("lat_fa_e2", frame_active, 1);
    chk("lat_en_e2", tx_en, 0);
    @(posedge clk); #1;
    chk("lat_en_e3", tx_en, 1);
    wait_done("single", 200);
    tb_seq = 8'd1;
    chk("single_seq", seq, 1);

    // Three events 5 cycles apart: second pending, third dropped
    push_frame(tb_seq, 8'h11, 8'h22);
    push_frame(8'(tb_seq + 1), 8'h33, 8'h44);
    fire(8'h11, 8'h22);
    repeat (3) @(posedge clk);
    #1;
    fire(8'h33, 8'h44);
    repeat (3) @(posedge clk);
    #1;
    fire(8'h55, 8'h66);
    tb_seq = tb_seq + 8'd2;
    wait_done("b2b", 400);
    chk("b2b_drop", drop_cnt, 1);
    chk("b2b_seq", seq, tb_seq);

    // Event landing in the same cycle as the slot is consumed: no drop
    push_frame(tb_seq, 8'h21, 8'h43);
    push_frame(8'(tb_seq + 1), 8'h65, 8'h87);
    glitch_ofs = 32'h0000_0021;
    glitch_dur = 32'h0000_0043;
    pulse_done = 1'b1;
    @(posedge clk); #1;
    pulse_done = 1'b0;
    glitch_ofs = 32'h0000_0065;
    glitch_dur = 32'h0000_0087;
    @(posedge clk); #1;
    pulse_done = 1'b1;
    @(posedge clk); #1;
    pulse_done = 1'b0;
    tb_seq = tb_seq + 8'd2;
    wait_done("same_cycle", 400);
    chk("same_cycle_drop", drop_cnt, 1);
    chk("same_cycle_seq", seq, tb_seq);

    // Transmitter never raises busy: every byte times out
    no_busy = 1'b1;
    push_frame(tb_seq, 8'h3C, 8'h5A);
    fire(8'h3C, 8'h5A);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (frame_active) cnt++;
    end
    tb_seq = tb_seq + 8'd1;
    chk("timeout_frame_len", cnt, 90);
    chk("timeout_left", exp_q.size(), 0);
    chk("timeout_seq", seq, tb_seq);
    no_busy = 1'b0;

    // Sequence wrap; seq FF / ofs FF / dur 00 must give CHK 00
    busy_len = 2;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] s;
      s = tb_seq;
      if (s == 8'hFF) begin
        exp_q.push_back(8'hA5); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        fire(8'hFF, 8'h00);
      end else begin
        push_frame(s, s, ~s);
        fire(s, ~s);
      end
      tb_seq = tb_seq + 8'd1;
      wait_done("wrap", 200);
      if (s == 8'hFF) chk("seq_wrap", seq, 0);
    end
    chk("seq_after_wrap", seq, tb_seq);
    chk("drop_after_wrap", drop_cnt, 1);

    // Reset during the third byte of a frame
    busy_len = 6;
    base = bytes_seen;
    push_frame(tb_seq, 8'h77, 8'h88);
    fire(8'h77, 8'h88);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (bytes_seen >= base + 3) break;
    end
    chk("byte3_reached", (bytes_seen >= base + 3) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_frame_active", frame_active, 0);
    chk("midrst_seq", seq, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_tx_en", tx_en, 0);
    exp_q.delete();
    rst = 1'b0;
    tb_seq = 8'd0;
    base = bytes_seen;
    repeat (20) @(posedge clk);
    #1;
    chk("no_tx_after_rst", bytes_seen, base);
    push_frame(8'h00, 8'h5A, 8'hC3);
    fire(8'h5A, 8'hC3);
    wait_done("post_rst", 200);
    chk("post_rst_seq", seq, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
